// File: rtl/cse_bubble_pkg.sv
// Shared definitions for the CSE-BUBBLE control path: opcodes, sequencer
// states and the opcode-to-class decode used by the sequencer.
package cse_bubble_pkg;

    localparam logic [5:0] OP_ADD     = 6'd0;
    localparam logic [5:0] OP_SUB     = 6'd1;
    localparam logic [5:0] OP_AND     = 6'd2;
    localparam logic [5:0] OP_OR      = 6'd3;
    localparam logic [5:0] OP_XOR     = 6'd4;
    localparam logic [5:0] OP_NOR     = 6'd5;
    localparam logic [5:0] OP_SLL     = 6'd6;
    localparam logic [5:0] OP_SRL     = 6'd7;
    localparam logic [5:0] OP_LW      = 6'd8;
    localparam logic [5:0] OP_SW      = 6'd9;
    localparam logic [5:0] OP_BEQ     = 6'd10;
    localparam logic [5:0] OP_BNE     = 6'd11;
    localparam logic [5:0] OP_BLT     = 6'd12;
    localparam logic [5:0] OP_BGE     = 6'd13;
    localparam logic [5:0] OP_BLE     = 6'd14;
    localparam logic [5:0] OP_BGT     = 6'd15;
    localparam logic [5:0] OP_J       = 6'd16;
    localparam logic [5:0] OP_JR      = 6'd17;
    localparam logic [5:0] OP_JAL     = 6'd18;
    localparam logic [5:0] OP_SLT     = 6'd19;
    localparam logic [5:0] OP_SLTI    = 6'd20;
    localparam logic [5:0] OP_IN      = 6'd21;
    localparam logic [5:0] OP_OUT     = 6'd22;
    localparam logic [5:0] OP_SYSCALL = 6'd23;
    localparam logic [5:0] OP_EXIT    = 6'd24;

    typedef enum logic [2:0] {
        ST_IDLE, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_SYS, ST_HALT
    } state_t;

    typedef enum logic [3:0] {
        CLS_ALU, CLS_LW, CLS_SW, CLS_BR, CLS_J, CLS_JAL, CLS_SYS, CLS_EXIT, CLS_ILL
    } op_class_t;

    function automatic op_class_t opcode_class(input logic [5:0] opcode);
        op_class_t cls;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLL, OP_SRL,
            OP_SLT, OP_SLTI:                         cls = CLS_ALU;
            OP_LW:                                   cls = CLS_LW;
            OP_SW:                                   cls = CLS_SW;
            OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLE,
            OP_BGT:                                  cls = CLS_BR;
            OP_J, OP_JR:                             cls = CLS_J;
            OP_JAL:                                  cls = CLS_JAL;
            OP_IN, OP_OUT, OP_SYSCALL:               cls = CLS_SYS;
            OP_EXIT:                                 cls = CLS_EXIT;
            default:                                 cls = CLS_ILL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/exec_watchdog.sv
// Wait-cycle counter for the MEM/SYS handshakes; flags expiry on the
// WAIT_LIMIT-th consecutive cycle without an acknowledge.
module exec_watchdog #(
    parameter int WAIT_LIMIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic i_active,
    input  logic i_ack,
    output logic o_expire
);

    localparam int W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT + 1) : 1;
    localparam logic [W-1:0] LAST = W'(WAIT_LIMIT - 1);

    logic [W-1:0] r_count;

    // Held at zero outside the wait states, so every entry starts from zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (!i_active || i_ack) begin
            r_count <= '0;
        end else if (r_count != LAST) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expire = i_active && !i_ack && (r_count == LAST);

endmodule

// File: rtl/exec_sequencer.sv
// Multi-cycle control FSM of the CSE-BUBBLE processor.
// Optional MEM/SYS wait watchdog enabled by defining EXEC_WATCHDOG_EN.
module exec_sequencer
    import cse_bubble_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int WAIT_LIMIT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      ir,
    input  logic [31:0]      pc,
    input  logic [31:0]      final_pc,
    input  logic             branch_taken,
    input  logic             mem_ack,
    input  logic             sys_done,
    output logic             ir_load,
    output logic             alu_en,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic             reg_we,
    output logic             link_we,
    output logic             pc_inc,
    output logic             pc_load,
    output logic             sys_en,
    output logic             busy,
    output logic             signal,
    output logic             illegal,
    output logic             timeout,
    output logic [CNT_W-1:0] retired
);

    state_t           r_state;
    state_t           w_state_next;
    op_class_t        w_cls;
    logic             w_retire;
    logic             w_set_ill;
    logic             w_expire;
    logic [CNT_W-1:0] r_retired;
    logic             r_illegal;
    logic             r_timeout;

    assign w_cls = opcode_class(ir[31:26]);
    wire w_unused_ir = ^ir[25:0];

`ifdef EXEC_WATCHDOG_EN
    logic w_waiting;
    logic w_ack;
    assign w_waiting = (r_state == ST_MEM) || (r_state == ST_SYS);
    assign w_ack     = (r_state == ST_MEM) ? mem_ack : sys_done;

    exec_watchdog #(
        .WAIT_LIMIT (WAIT_LIMIT)
    ) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .i_active (w_waiting),
        .i_ack    (w_ack),
        .o_expire (w_expire)
    );
`else
    assign w_expire = 1'b0;
    wire w_unused_limit = (WAIT_LIMIT > 0);
`endif

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (start) w_state_next = ST_FETCH;
            ST_FETCH:  w_state_next = (pc == final_pc) ? ST_HALT : ST_DECODE;
            ST_DECODE: begin
                case (w_cls)
                    CLS_SYS:           w_state_next = ST_SYS;
                    CLS_EXIT, CLS_ILL: w_state_next = ST_HALT;
                    default:           w_state_next = ST_EXEC;
                endcase
            end
            ST_EXEC: begin
                case (w_cls)
                    CLS_ALU:              w_state_next = ST_WB;
                    CLS_LW, CLS_SW:       w_state_next = ST_MEM;
                    CLS_BR, CLS_J, CLS_JAL: w_state_next = ST_FETCH;
                    default:              w_state_next = ST_HALT;
                endcase
            end
            ST_MEM: begin
                if (mem_ack)       w_state_next = (w_cls == CLS_LW) ? ST_WB : ST_FETCH;
                else if (w_expire) w_state_next = ST_HALT;
            end
            ST_WB:     w_state_next = ST_FETCH;
            ST_SYS: begin
                if (sys_done)      w_state_next = ST_FETCH;
                else if (w_expire) w_state_next = ST_HALT;
            end
            default:   w_state_next = ST_HALT;
        endcase
    end

    // The IDLE->FETCH launch is not a completed instruction.
    assign w_retire  = ((w_state_next == ST_FETCH) && (r_state != ST_IDLE)) ||
                       ((r_state == ST_DECODE) && (w_cls == CLS_EXIT));
    assign w_set_ill = (r_state == ST_DECODE) && (w_cls == CLS_ILL);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_retired <= '0;
            r_illegal <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_retire && (r_retired != '1)) r_retired <= r_retired + 1'b1;
            if (w_set_ill) r_illegal <= 1'b1;
            if (w_expire)  r_timeout <= 1'b1;
        end
    end

    // Strobes decode from the state register, so an async reset clears them at once.
    always_comb begin
        ir_load = 1'b0;
        alu_en  = 1'b0;
        mem_rd  = 1'b0;
        mem_wr  = 1'b0;
        reg_we  = 1'b0;
        link_we = 1'b0;
        pc_inc  = 1'b0;
        pc_load = 1'b0;
        sys_en  = 1'b0;
        case (r_state)
            ST_FETCH: ir_load = (pc != final_pc);
            ST_EXEC: begin
                alu_en = 1'b1;
                case (w_cls)
                    CLS_BR: begin
                        pc_load = branch_taken;
                        pc_inc  = !branch_taken;
                    end
                    CLS_J:   pc_load = 1'b1;
                    CLS_JAL: begin
                        pc_load = 1'b1;
                        link_we = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_MEM: begin
                mem_rd = (w_cls == CLS_LW);
                mem_wr = (w_cls == CLS_SW);
                pc_inc = (w_cls == CLS_SW) && mem_ack;
            end
            ST_WB: begin
                reg_we = 1'b1;
                pc_inc = 1'b1;
            end
            ST_SYS: begin
                sys_en = 1'b1;
                pc_inc = sys_done;
            end
            default: ;
        endcase
    end

    assign busy    = (r_state != ST_IDLE) && (r_state != ST_HALT);
    assign signal  = (r_state == ST_HALT);
    assign illegal = r_illegal;
    assign timeout = r_timeout;
    assign retired = r_retired;

endmodule

// File: tb/tb_exec_sequencer.sv
// Bench for exec_sequencer: single-instruction programs from a vector table,
// checked per instruction against a scoreboard, plus reset and multi-instruction sequences.
module tb_exec_sequencer;
    import cse_bubble_pkg::*;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [31:0]      final_pc = 32'd0;
    logic             branch_taken = 1'b0;
    logic             mem_ack = 1'b0;
    logic             sys_done = 1'b0;
    logic             ir_load, alu_en, mem_rd, mem_wr, reg_we, link_we;
    logic             pc_inc, pc_load, sys_en, busy, signal, illegal, timeout;
    logic [CNT_W-1:0] retired;
    logic [31:0]      r_ir, r_pc;
    logic [31:0]      imem [0:15];

    always #5 clk = ~clk;

    exec_sequencer #(.CNT_W(CNT_W), .WAIT_LIMIT(4)) dut (
        .clk(clk), .reset(reset), .start(start), .ir(r_ir), .pc(r_pc),
        .final_pc(final_pc), .branch_taken(branch_taken), .mem_ack(mem_ack),
        .sys_done(sys_done), .ir_load(ir_load), .alu_en(alu_en), .mem_rd(mem_rd),
        .mem_wr(mem_wr), .reg_we(reg_we), .link_we(link_we), .pc_inc(pc_inc),
        .pc_load(pc_load), .sys_en(sys_en), .busy(busy), .signal(signal),
        .illegal(illegal), .timeout(timeout), .retired(retired)
    );

    // Minimal IR/PC datapath obeying the strobes.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc <= 32'd0;
            r_ir <= 32'd0;
        end else begin
            if (ir_load) r_ir <= imem[r_pc[3:0]];
            if (pc_inc) r_pc <= r_pc + 32'd1;
            else if (pc_load) r_pc <= {6'd0, r_ir[25:0]};
        end
    end

    typedef struct {
        int cyc; int alu; int mem; int rwe; int lnk; int inc; int ld; int sys;
    } exp_t;

    typedef struct {
        logic [5:0]  op;
        logic        taken;
        int          mcyc;
        int          scyc;
        logic [25:0] target;
        logic [31:0] fpc;
        exp_t        e;
        int          ill;
        int          ret;
        int          tmo;
    } vec_t;

    vec_t vecs [0:23];
    int   n_vecs = 0;
    exp_t sb [$];

    int n_vec = 0, n_fail = 0;
    int mcyc = 0, scyc = 0, mcnt = 0, scnt = 0;
    bit ack_force = 1'b0;
    bit in_instr = 1'b0;
    int m_cyc, m_alu, m_mem, m_rwe, m_lnk, m_inc, m_ld, m_sys, m_busy;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [5:0] op, input logic taken, input int mc, input int sc,
                           input logic [25:0] tgt, input logic [31:0] fpc,
                           input int cyc, input int alu, input int mem, input int rwe,
                           input int lnk, input int inc, input int ld, input int sys,
                           input int ill, input int ret, input int tmo);
        vecs[n_vecs].op = op;   vecs[n_vecs].taken = taken;
        vecs[n_vecs].mcyc = mc; vecs[n_vecs].scyc = sc;
        vecs[n_vecs].target = tgt; vecs[n_vecs].fpc = fpc;
        vecs[n_vecs].e = '{cyc, alu, mem, rwe, lnk, inc, ld, sys};
        vecs[n_vecs].ill = ill; vecs[n_vecs].ret = ret; vecs[n_vecs].tmo = tmo;
        n_vecs++;
    endtask

    task automatic close_instr();
        exp_t e;
        in_instr = 1'b0;
        if (sb.size() == 0) begin
            chk("scoreboard_underflow", 1, 0);
            return;
        end
        e = sb.pop_front();
        chk("instr_cycles", m_cyc, e.cyc);
        chk("alu_en_cycles", m_alu, e.alu);
        chk("mem_req_cycles", m_mem, e.mem);
        chk("reg_we_cycles", m_rwe, e.rwe);
        chk("link_we_cycles", m_lnk, e.lnk);
        chk("pc_inc_cycles", m_inc, e.inc);
        chk("pc_load_cycles", m_ld, e.ld);
        chk("sys_en_cycles", m_sys, e.sys);
    endtask

    // An instruction spans its ir_load cycle through the cycle that moves the PC,
    // or up to (not including) HALT for exit/illegal/timeout.
    task automatic monitor();
        chk("pc_inc_and_pc_load", int'(pc_inc && pc_load), 0);
        chk("mem_rd_and_mem_wr", int'(mem_rd && mem_wr), 0);
        if (busy) m_busy++;
        if (ir_load) begin
            if (in_instr) chk("instr_overlap", 1, 0);
            in_instr = 1'b1;
            m_cyc = 0; m_alu = 0; m_mem = 0; m_rwe = 0;
            m_lnk = 0; m_inc = 0; m_ld = 0; m_sys = 0;
        end
        if (in_instr && signal) begin
            close_instr();
        end else if (in_instr) begin
            m_cyc++;
            m_alu += int'(alu_en);
            m_mem += int'(mem_rd || mem_wr);
            m_rwe += int'(reg_we);
            m_lnk += int'(link_we);
            m_inc += int'(pc_inc);
            m_ld  += int'(pc_load);
            m_sys += int'(sys_en);
            if (pc_inc || pc_load) close_instr();
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        if (mem_rd || mem_wr) mcnt++; else mcnt = 0;
        if (sys_en) scnt++; else scnt = 0;
        mem_ack  = ack_force || ((mem_rd || mem_wr) && (mcyc != 0) && (mcnt == mcyc));
        sys_done = sys_en && (scyc != 0) && (scnt == scyc);
        #1;
        monitor();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        mem_ack = 1'b0;
        sys_done = 1'b0;
        ack_force = 1'b0;
        repeat (2) @(negedge clk);
        in_instr = 1'b0;
        sb.delete();
        m_busy = 0;
        mcnt = 0;
        scnt = 0;
        reset = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic wait_halt(input int limit);
        for (int k = 0; k < limit && !signal; k++) cycle();
        chk("halt_reached", int'(signal), 1);
    endtask

    initial begin
        exp_t e_add, e_sw;
        for (int i = 0; i < 16; i++) imem[i] = 32'd0;
        e_add = '{4, 1, 0, 1, 0, 1, 0, 0};
        e_sw  = '{4, 1, 1, 0, 0, 1, 0, 0};

        //      op         tk mc sc tgt fpc  cyc alu mem rwe lnk inc ld sys ill ret tmo
        add_vec(OP_ADD,     0, 0, 0, 0, 1,    4, 1, 0, 1, 0, 1, 0, 0,  0, 1, 0);
        add_vec(OP_SRL,     0, 0, 0, 0, 1,    4, 1, 0, 1, 0, 1, 0, 0,  0, 1, 0);
        add_vec(OP_SLTI,    0, 0, 0, 0, 1,    4, 1, 0, 1, 0, 1, 0, 0,  0, 1, 0);
        add_vec(OP_LW,      0, 3, 0, 0, 1,    7, 1, 3, 1, 0, 1, 0, 0,  0, 1, 0);
        add_vec(OP_LW,      0, 1, 0, 0, 1,    5, 1, 1, 1, 0, 1, 0, 0,  0, 1, 0);
        add_vec(OP_SW,      0, 1, 0, 0, 1,    4, 1, 1, 0, 0, 1, 0, 0,  0, 1, 0);
        add_vec(OP_SW,      0, 2, 0, 0, 1,    5, 1, 2, 0, 0, 1, 0, 0,  0, 1, 0);
        add_vec(OP_BEQ,     1, 0, 0, 5, 5,    3, 1, 0, 0, 0, 0, 1, 0,  0, 1, 0);
        add_vec(OP_BEQ,     0, 0, 0, 5, 1,    3, 1, 0, 0, 0, 1, 0, 0,  0, 1, 0);
        add_vec(OP_BGT,     1, 0, 0, 7, 7,    3, 1, 0, 0, 0, 0, 1, 0,  0, 1, 0);
        add_vec(OP_J,       0, 0, 0, 9, 9,    3, 1, 0, 0, 0, 0, 1, 0,  0, 1, 0);
        add_vec(OP_JR,      0, 0, 0, 3, 3,    3, 1, 0, 0, 0, 0, 1, 0,  0, 1, 0);
        add_vec(OP_JAL,     0, 0, 0, 4, 4,    3, 1, 0, 0, 1, 0, 1, 0,  0, 1, 0);
        add_vec(OP_IN,      0, 0, 1, 0, 1,    3, 0, 0, 0, 0, 1, 0, 1,  0, 1, 0);
        add_vec(OP_SYSCALL, 0, 0, 4, 0, 1,    6, 0, 0, 0, 0, 1, 0, 4,  0, 1, 0);
        add_vec(OP_EXIT,    0, 0, 0, 0, 1,    2, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0);
        add_vec(6'd25,      0, 0, 0, 0, 1,    2, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0);
        add_vec(6'd30,      0, 0, 0, 0, 1,    2, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0);
        add_vec(6'd63,      0, 0, 0, 0, 1,    2, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0);
`ifdef EXEC_WATCHDOG_EN
        add_vec(OP_OUT,     0, 0, 0, 0, 1,    6, 0, 0, 0, 0, 0, 0, 4,  0, 0, 1);
        add_vec(OP_LW,      0, 0, 0, 0, 1,    7, 1, 4, 0, 0, 0, 0, 0,  0, 0, 1);
`endif

        // Reset state, sampled while reset is still held.
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_strobes", int'({ir_load, alu_en, mem_rd, mem_wr, reg_we, link_we,
                                   pc_inc, pc_load, sys_en}), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_signal", int'(signal), 0);
        chk("reset_flags", int'({illegal, timeout}), 0);
        chk("reset_retired", int'(retired), 0);

        for (int v = 0; v < n_vecs; v++) begin
            do_reset();
            imem[0] = {vecs[v].op, vecs[v].target};
            final_pc = vecs[v].fpc;
            branch_taken = vecs[v].taken;
            mcyc = vecs[v].mcyc;
            scyc = vecs[v].scyc;
            sb.push_back(vecs[v].e);
            pulse_start();
            wait_halt(60);
            cycle();
            chk("halt_signal", int'(signal), 1);
            chk("halt_busy", int'(busy), 0);
            chk("retired", int'(retired), vecs[v].ret);
            chk("illegal", int'(illegal), vecs[v].ill);
            chk("timeout", int'(timeout), vecs[v].tmo);
            chk("scoreboard_drained", sb.size(), 0);
            $display("vec %0d op=%0d taken=%0d mem_cycles=%0d sys_cycles=%0d -> retired=%0d illegal=%0d timeout=%0d",
                     v, vecs[v].op, vecs[v].taken, vecs[v].mcyc, vecs[v].scyc,
                     retired, illegal, timeout);
        end

        // Three adds, final_pc=3: 3x4 instruction cycles plus the terminating FETCH.
        do_reset();
        for (int i = 0; i < 3; i++) imem[i] = {OP_ADD, 26'd0};
        final_pc = 32'd3;
        mcyc = 0; scyc = 0;
        for (int i = 0; i < 3; i++) sb.push_back(e_add);
        pulse_start();
        wait_halt(60);
        chk("prog3_busy_cycles", m_busy, 13);
        chk("prog3_retired", int'(retired), 3);
        chk("prog3_signal", int'(signal), 1);
        chk("prog3_scoreboard_drained", sb.size(), 0);
        start = 1'b1;
        repeat (3) cycle();
        start = 1'b0;
        chk("halt_ignores_start", int'({signal, busy}), 2);
        $display("prog3 busy_cycles=%0d retired=%0d", m_busy, retired);

        // Reset in the middle of a never-acked store.
        do_reset();
        imem[0] = {OP_SW, 26'd0};
        final_pc = 32'd1;
        mcyc = 0;
        pulse_start();
        for (int k = 0; k < 20 && !mem_wr; k++) cycle();
        chk("sw_mem_wr_reached", int'(mem_wr), 1);
        reset = 1'b1;
        #1;
        chk("reset_drops_mem_wr", int'(mem_wr), 0);
        chk("reset_drops_busy", int'(busy), 0);
        @(negedge clk);
        reset = 1'b0;
        in_instr = 1'b0;
        sb.delete();
        ack_force = 1'b1;
        repeat (3) cycle();
        chk("idle_ignores_ack_busy", int'(busy), 0);
        chk("idle_ignores_ack_state", int'({signal, mem_wr, pc_inc}), 0);
        chk("idle_retired", int'(retired), 0);
        ack_force = 1'b0;
        mcyc = 1;
        sb.push_back(e_sw);
        pulse_start();
        wait_halt(60);
        chk("restart_retired", int'(retired), 1);
        chk("restart_scoreboard_drained", sb.size(), 0);
        $display("reset-mid-mem restart retired=%0d", retired);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
